cipher_block_ctrl: RTL and testbench
====================================

CIPHER_BLOCK_CTRL -- requirements
Module: cipher_block_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 4096: maximum cycles the block waits for a core result before aborting.
REQ-002 Parameter SETTLE_CYCLES, default 3: idle cycles inserted after a mode change so the core's encrypt synchronizer settles.
REQ-003 clk  input  1  system clock; the block has one clock.
REQ-004 n_rst  input  1  reset, asynchronous, active-low.
REQ-005 rx_byte  input  8  incoming plaintext/ciphertext byte.
REQ-006 rx_valid / rx_ready  input / output  1 each  upstream byte handshake; a byte transfers when both are high on a clk edge.
REQ-007 mode_encrypt  input  1  1 = encrypt, 0 = decrypt; sampled at block start.
REQ-008 core_rcv_data  output  64  block presented to the encryptor core.
REQ-009 core_rcv_data_ready  output  1  single-cycle start pulse to the core.
REQ-010 core_encrypt  output  1  mode level driven to the core.
REQ-011 core_trans_data / core_trans_data_ready  input  64 / 1  core result and its ready flag.
REQ-012 core_handshake_ack  output  1  result-consumed acknowledge to the core.
REQ-013 tx_byte / tx_valid / tx_ready  output / output / input  8 / 1 / 1  downstream byte handshake with the same transfer rule as rx.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 timeout_err  output  1  sticky flag; set on a core timeout.

Function
REQ-016 The FSM SHALL have states IDLE, FILL, SETTLE, ISSUE, WAIT_CORE, ACK and DRAIN.
REQ-017 IDLE: rx_ready=1. The first accepted byte latches mode_encrypt and the FSM moves to FILL.
REQ-018 FILL: bytes pack big-endian, the first byte into [63:56]. After the 8th byte, rx_ready drops in the same cycle. The FSM then goes to SETTLE if the latched mode differs from the last issued mode (or no block has been issued since reset); otherwise it goes to ISSUE.
REQ-019 core_encrypt SHALL update only on the FILL exit and hold stable until the next FILL exit.
REQ-020 SETTLE: wait exactly SETTLE_CYCLES cycles, then go to ISSUE.
REQ-021 ISSUE: core_rcv_data is stable. core_rcv_data_ready is high for exactly one cycle, then the FSM goes to WAIT_CORE.
REQ-022 WAIT_CORE: a 13-bit-min counter increments each cycle.
  - core_trans_data_ready=1 captures core_trans_data into the output shift register and goes to ACK.
  - Counter reaching TIMEOUT_CYCLES sets timeout_err, discards the block and goes to ACK.
REQ-023 ACK: core_handshake_ack is high for exactly 2 cycles, then the FSM goes to DRAIN (normal) or IDLE (timeout).
REQ-024 DRAIN: tx_byte = captured [63:56] first. tx_valid stays high. The register shifts by 8 on each transfer. After the 8th transfer the FSM goes to IDLE.
REQ-025 tx_valid and tx_byte SHALL hold while tx_ready=0; there is no limit on back-pressure duration.
REQ-026 rx_ready SHALL be 0 in every state except IDLE and FILL; rx_valid there is ignored.
REQ-027 A mode_encrypt change mid-block SHALL NOT affect the block in flight.
REQ-028 core_trans_data_ready seen outside WAIT_CORE SHALL be ignored.
REQ-029 timeout_err SHALL clear only on reset.
REQ-030 Latency: last rx byte to core_rcv_data_ready is 1 cycle without mode change, SETTLE_CYCLES+1 with one. core_trans_data_ready to first tx_valid is 3 cycles.

Reset
REQ-031 On n_rst low, immediately (asynchronously):
  - FSM goes to IDLE.
  - All outputs are 0 except rx_ready=1 and core_encrypt=1.
  - Counters and data registers are cleared, and timeout_err is cleared.
  - The "last issued mode" is marked invalid.
REQ-032 Reset mid-block SHALL abort it with no core pulse and no tx output after release.

Structure
REQ-033 Package cipher_pkg SHALL hold the state enum, the block width (64) and the byte count (8).
REQ-034 Sub-module block_packer (8-byte shift-in / shift-out register with byte counter) SHALL be instantiated once, shared by FILL and DRAIN.

Verification
REQ-035 Encrypt path:
  - Stimulus: mode=1, bytes 67 5A 69 67 5E 5A 6B 5A; core model returns 64'hC1392F3D4C0A6588 after 40 cycles.
  - Required: core_rcv_data=64'h675A69675E5A6B5A, one ready pulse, 2-cycle ack, tx bytes C1 39 2F 3D 4C 0A 65 88.
REQ-036 Mode switch:
  - Stimulus: second block with mode=0, bytes C1...88.
  - Required: core_encrypt falls at FILL exit, exactly 3 SETTLE cycles, tx bytes 67 5A 69 67 5E 5A 6B 5A.
REQ-037 Timeout:
  - Stimulus: core never asserts ready, TIMEOUT_CYCLES=16.
  - Required: timeout_err=1 at cycle 16, ack 2 cycles, no tx_valid, return to IDLE.
REQ-038 Back-pressure:
  - Stimulus: tx_ready toggles 0/1 every 3 cycles during DRAIN.
  - Required: byte order preserved, tx_byte stable while stalled, rx_ready=0 throughout.
REQ-039 Reset mid-WAIT_CORE:
  - Stimulus: assert n_rst low mid-WAIT_CORE.
  - Required: busy=0 asynchronously; a late core_trans_data_ready after release produces no tx_valid.

Source files
------------

// File: rtl/cipher_pkg.sv
// rtl/cipher_pkg.sv - shared state encoding and block geometry for the cipher block controller
package cipher_pkg;

    localparam int BLOCK_W    = 64;
    localparam int BYTE_COUNT = 8;
    localparam int BCNT_W     = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_SETTLE,
        ST_ISSUE,
        ST_WAIT_CORE,
        ST_ACK,
        ST_DRAIN
    } state_t;

endpackage

// File: rtl/block_packer.sv
// rtl/block_packer.sv - 8-byte big-endian shift register with byte counter, shared by fill and drain
module block_packer
    import cipher_pkg::*;
(
    input  logic               clk,
    input  logic               n_rst,
    input  logic               clear,
    input  logic               load,
    input  logic [BLOCK_W-1:0] load_data,
    input  logic               shift_in,
    input  logic [7:0]         byte_in,
    input  logic               shift_out,
    output logic [BLOCK_W-1:0] data,
    output logic [BCNT_W-1:0]  count
);

    // Both directions shift toward the MSB so the first byte in is the first byte out.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            data  <= '0;
            count <= '0;
        end else if (clear) begin
            data  <= '0;
            count <= '0;
        end else if (load) begin
            data  <= load_data;
            count <= '0;
        end else if (shift_in) begin
            data  <= {data[BLOCK_W-9:0], byte_in};
            count <= count + BCNT_W'(1);
        end else if (shift_out) begin
            data  <= {data[BLOCK_W-9:0], 8'h00};
            count <= count + BCNT_W'(1);
        end
    end

endmodule

// File: rtl/cipher_block_ctrl.sv
// rtl/cipher_block_ctrl.sv - byte-stream to 64-bit cipher core sequencer with settle, timeout and drain
module cipher_block_ctrl
    import cipher_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int SETTLE_CYCLES  = 3
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic [7:0]         rx_byte,
    input  logic               rx_valid,
    output logic               rx_ready,
    input  logic               mode_encrypt,
    output logic [BLOCK_W-1:0] core_rcv_data,
    output logic               core_rcv_data_ready,
    output logic               core_encrypt,
    input  logic [BLOCK_W-1:0] core_trans_data,
    input  logic               core_trans_data_ready,
    output logic               core_handshake_ack,
    output logic [7:0]         tx_byte,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic               busy,
    output logic               timeout_err
);

    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 13) ? $clog2(TIMEOUT_CYCLES + 1) : 13;
    localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  ACK_LAST     = CNT_W'(1);
    localparam logic [BCNT_W-1:0] LAST_BYTE    = BCNT_W'(BYTE_COUNT - 1);

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cyc_cnt;
    logic               mode_latched;
    logic               last_mode_valid;
    logic               aborted;
    logic               mode_change;
    logic               fill_done;
    logic               set_timeout;
    logic               pk_clear;
    logic               pk_load;
    logic               pk_shift_in;
    logic               pk_shift_out;
    logic [BLOCK_W-1:0] pk_data;
    logic [BCNT_W-1:0]  pk_count;

    block_packer u_packer (
        .clk       (clk),
        .n_rst     (n_rst),
        .clear     (pk_clear),
        .load      (pk_load),
        .load_data (core_trans_data),
        .shift_in  (pk_shift_in),
        .byte_in   (rx_byte),
        .shift_out (pk_shift_out),
        .data      (pk_data),
        .count     (pk_count)
    );

    // The core's encrypt synchronizer only needs settling when the level actually moves.
    assign mode_change = (SETTLE_CYCLES > 0) &&
                         (!last_mode_valid || (mode_latched != core_encrypt));

    always_comb begin
        state_next          = state;
        rx_ready            = 1'b0;
        core_rcv_data_ready = 1'b0;
        core_handshake_ack  = 1'b0;
        tx_valid            = 1'b0;
        pk_clear            = 1'b0;
        pk_load             = 1'b0;
        pk_shift_in         = 1'b0;
        pk_shift_out        = 1'b0;
        fill_done           = 1'b0;
        set_timeout         = 1'b0;
        case (state)
            ST_IDLE: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    pk_shift_in = 1'b1;
                    state_next  = ST_FILL;
                end
            end
            ST_FILL: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    pk_shift_in = 1'b1;
                    if (pk_count == LAST_BYTE) begin
                        fill_done  = 1'b1;
                        state_next = mode_change ? ST_SETTLE : ST_ISSUE;
                    end
                end
            end
            ST_SETTLE: begin
                if (cyc_cnt == SETTLE_LAST) state_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                core_rcv_data_ready = 1'b1;
                state_next          = ST_WAIT_CORE;
            end
            ST_WAIT_CORE: begin
                if (core_trans_data_ready) begin
                    pk_load    = 1'b1;
                    state_next = ST_ACK;
                end else if (cyc_cnt == TIMEOUT_LAST) begin
                    set_timeout = 1'b1;
                    state_next  = ST_ACK;
                end
            end
            ST_ACK: begin
                core_handshake_ack = 1'b1;
                if (cyc_cnt == ACK_LAST) begin
                    if (aborted) begin
                        pk_clear   = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                tx_valid = 1'b1;
                if (tx_ready) begin
                    pk_shift_out = 1'b1;
                    if (pk_count == LAST_BYTE) begin
                        pk_clear   = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // cyc_cnt restarts on every state change, so it times SETTLE, WAIT_CORE and ACK alike.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state           <= ST_IDLE;
            cyc_cnt         <= '0;
            mode_latched    <= 1'b0;
            last_mode_valid <= 1'b0;
            core_encrypt    <= 1'b1;
            timeout_err     <= 1'b0;
            aborted         <= 1'b0;
        end else begin
            state <= state_next;
            if (state_next != state) cyc_cnt <= '0;
            else                     cyc_cnt <= cyc_cnt + CNT_W'(1);
            if (state == ST_IDLE && rx_valid) mode_latched <= mode_encrypt;
            if (fill_done) begin
                core_encrypt    <= mode_latched;
                last_mode_valid <= 1'b1;
            end
            if (set_timeout) begin
                timeout_err <= 1'b1;
                aborted     <= 1'b1;
            end else if (state == ST_ISSUE) begin
                aborted <= 1'b0;
            end
        end
    end

    assign core_rcv_data = pk_data;
    assign tx_byte       = (state == ST_DRAIN) ? pk_data[BLOCK_W-1 -: 8] : 8'h00;
    assign busy          = (state != ST_IDLE);

endmodule

// File: tb/tb_cipher_block_ctrl.sv
// tb/tb_cipher_block_ctrl.sv - self-checking bench for cipher_block_ctrl
module tb_cipher_block_ctrl;

    localparam int SETTLE   = 3;
    localparam int TMO_MAIN = 64;
    localparam int TMO_T    = 16;

    logic tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    logic        n_rst, rx_valid, rx_ready, mode_encrypt;
    logic [7:0]  rx_byte, tx_byte;
    logic [63:0] core_rcv_data, core_trans_data;
    logic        core_rcv_data_ready, core_encrypt, core_trans_data_ready, core_handshake_ack;
    logic        tx_valid, tx_ready, busy, timeout_err;

    logic        t_n_rst, t_rx_valid, t_rx_ready, t_mode;
    logic [7:0]  t_rx_byte, t_tx_byte;
    logic [63:0] t_rcv_data, t_trans_data;
    logic        t_rcv_ready, t_enc, t_trans_ready, t_ack, t_tx_valid, t_tx_ready, t_busy, t_err;

    cipher_block_ctrl #(.TIMEOUT_CYCLES(TMO_MAIN), .SETTLE_CYCLES(SETTLE)) dut (
        .clk(tb_clk), .n_rst(n_rst), .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .mode_encrypt(mode_encrypt), .core_rcv_data(core_rcv_data),
        .core_rcv_data_ready(core_rcv_data_ready), .core_encrypt(core_encrypt),
        .core_trans_data(core_trans_data), .core_trans_data_ready(core_trans_data_ready),
        .core_handshake_ack(core_handshake_ack), .tx_byte(tx_byte), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .busy(busy), .timeout_err(timeout_err)
    );

    cipher_block_ctrl #(.TIMEOUT_CYCLES(TMO_T), .SETTLE_CYCLES(SETTLE)) dut_t (
        .clk(tb_clk), .n_rst(t_n_rst), .rx_byte(t_rx_byte), .rx_valid(t_rx_valid),
        .rx_ready(t_rx_ready), .mode_encrypt(t_mode), .core_rcv_data(t_rcv_data),
        .core_rcv_data_ready(t_rcv_ready), .core_encrypt(t_enc), .core_trans_data(t_trans_data),
        .core_trans_data_ready(t_trans_ready), .core_handshake_ack(t_ack), .tx_byte(t_tx_byte),
        .tx_valid(t_tx_valid), .tx_ready(t_tx_ready), .busy(t_busy), .timeout_err(t_err)
    );

    int tests = 0;
    int fails = 0;

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Transaction-level model: block assembly, expected pulse/ack cycles and the tx byte queue.
    int          cyc = 0;
    bit          m_collect = 1'b1;
    int          m_nbytes = 0;
    logic [63:0] m_blk = '0;
    bit          m_mode = 1'b1;
    bit          m_enc = 1'b1;
    bit          m_last_valid = 1'b0;
    int          m_issue_at = -1;
    bit          m_waiting = 1'b0;
    int          m_cap_at = -1;
    logic [7:0]  m_txq[$];

    int          last_rx_cyc, pulse_cyc, pulse_cnt, ack_cnt, tx_valid_cnt, rec_n;
    logic [63:0] pulse_data, rec_word;

    task automatic clear_obs();
        pulse_cnt = 0; ack_cnt = 0; tx_valid_cnt = 0; rec_n = 0;
        rec_word = '0; pulse_data = '0; pulse_cyc = 0; last_rx_cyc = 0;
    endtask

    initial begin
        bit draining;
        forever begin
            @(negedge tb_clk);
            cyc++;
            if (!n_rst) begin
                m_collect = 1'b1; m_nbytes = 0; m_enc = 1'b1; m_last_valid = 1'b0;
                m_issue_at = -1; m_waiting = 1'b0; m_cap_at = -1; m_txq.delete();
                check_bit("rst_rx_ready", rx_ready, 1'b1);
                check_bit("rst_busy", busy, 1'b0);
                check_bit("rst_core_encrypt", core_encrypt, 1'b1);
                check_bit("rst_rcv_ready", core_rcv_data_ready, 1'b0);
                check_bit("rst_ack", core_handshake_ack, 1'b0);
                check_bit("rst_tx_valid", tx_valid, 1'b0);
                check_bit("rst_timeout_err", timeout_err, 1'b0);
                check_val("rst_rcv_data", core_rcv_data, 64'h0);
                check_val("rst_tx_byte", 64'(tx_byte), 64'h0);
            end else begin
                draining = (m_cap_at >= 0) && (cyc >= m_cap_at + 3) && (m_txq.size() > 0);
                check_bit("rx_ready", rx_ready, m_collect);
                check_bit("busy", busy, !(m_collect && m_nbytes == 0));
                check_bit("core_encrypt", core_encrypt, m_enc);
                check_bit("rcv_pulse", core_rcv_data_ready, cyc == m_issue_at);
                if (cyc == m_issue_at) check_val("rcv_data", core_rcv_data, m_blk);
                check_bit("ack", core_handshake_ack,
                          (m_cap_at >= 0) && (cyc == m_cap_at + 1 || cyc == m_cap_at + 2));
                check_bit("tx_valid", tx_valid, draining);
                if (draining) check_val("tx_byte", 64'(tx_byte), 64'(m_txq[0]));
                check_bit("timeout_err", timeout_err, 1'b0);

                if (rx_valid && rx_ready) last_rx_cyc = cyc;
                if (core_rcv_data_ready) begin
                    pulse_cnt++; pulse_cyc = cyc; pulse_data = core_rcv_data;
                end
                if (core_handshake_ack) ack_cnt++;
                if (tx_valid) tx_valid_cnt++;
                if (tx_valid && tx_ready) begin
                    rec_word = {rec_word[55:0], tx_byte};
                    rec_n++;
                end

                if (rx_valid && m_collect) begin
                    if (m_nbytes == 0) m_mode = mode_encrypt;
                    m_blk = {m_blk[55:0], rx_byte};
                    m_nbytes++;
                    if (m_nbytes == 8) begin
                        m_collect    = 1'b0;
                        m_issue_at   = cyc + ((!m_last_valid || m_mode != m_enc) ? SETTLE + 1 : 1);
                        m_enc        = m_mode;
                        m_last_valid = 1'b1;
                    end
                end
                if (cyc == m_issue_at) begin
                    m_waiting = 1'b1;
                end else if (m_waiting && core_trans_data_ready) begin
                    m_waiting = 1'b0;
                    m_cap_at  = cyc;
                    for (int i = 7; i >= 0; i--) m_txq.push_back(core_trans_data[i*8 +: 8]);
                end
                if (draining && tx_ready) begin
                    void'(m_txq.pop_front());
                    if (m_txq.size() == 0) begin
                        m_collect = 1'b1; m_nbytes = 0; m_cap_at = -1;
                    end
                end
            end
        end
    end

    task automatic send_block(input logic [63:0] blk, input bit mode, input bit flip_mode);
        for (int i = 7; i >= 0; i--) begin
            int n = 0;
            rx_byte  = blk[i*8 +: 8];
            rx_valid = 1'b1;
            if (i == 7) mode_encrypt = mode;
            do begin
                @(negedge tb_clk);
                n++;
            end while (!rx_ready && n < 50);
            if (!rx_ready) check_bit("send_rx_ready", rx_ready, 1'b1);
            @(posedge tb_clk);
            #1;
            if (flip_mode && i == 7) mode_encrypt = ~mode;
        end
        rx_valid = 1'b0;
    endtask

    task automatic core_respond(input int delay, input logic [63:0] res, input bit poke_rx);
        int n = 0;
        while (!core_rcv_data_ready && n < 500) begin
            @(negedge tb_clk);
            n++;
        end
        check_bit("core_pulse_seen", core_rcv_data_ready, 1'b1);
        @(posedge tb_clk);
        #1;
        if (poke_rx) begin
            rx_byte  = 8'hEE;
            rx_valid = 1'b1;
        end
        repeat (delay - 1) @(posedge tb_clk);
        #1;
        rx_valid              = 1'b0;
        core_trans_data       = res;
        core_trans_data_ready = 1'b1;
        @(posedge tb_clk);
        #1;
        core_trans_data_ready = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        do begin
            @(negedge tb_clk);
            n++;
        end while (busy && n < 2000);
        check_bit(name, busy, 1'b0);
        @(posedge tb_clk);
        #1;
    endtask

    task automatic drain_backpressure();
        int n = 0;
        tx_ready = 1'b0;
        while (!tx_valid && n < 500) begin
            @(negedge tb_clk);
            n++;
        end
        check_bit("bp_drain_start", tx_valid, 1'b1);
        n = 0;
        while (busy && n < 300) begin
            @(posedge tb_clk);
            #1;
            tx_ready = ((n / 3) % 2) == 1;
            n++;
        end
        tx_ready = 1'b1;
    endtask

    initial begin
        int n, err_k, idle_k, t_ack_cnt, t_txv_cnt;
        n_rst = 1'b0; rx_byte = '0; rx_valid = 1'b0; mode_encrypt = 1'b1;
        core_trans_data = '0; core_trans_data_ready = 1'b0; tx_ready = 1'b1;
        t_n_rst = 1'b0; t_rx_byte = '0; t_rx_valid = 1'b0; t_mode = 1'b1;
        t_trans_data = '0; t_trans_ready = 1'b0; t_tx_ready = 1'b1;
        clear_obs();
        repeat (3) @(posedge tb_clk);
        #2;
        n_rst = 1'b1;
        @(posedge tb_clk);
        #1;

        // Encrypt path; mode input flips after the first byte and must not matter.
        clear_obs();
        fork
            send_block(64'h675A69675E5A6B5A, 1'b1, 1'b1);
            core_respond(40, 64'hC1392F3D4C0A6588, 1'b0);
        join
        wait_idle("blk1_idle");
        check_val("blk1_rcv_data", pulse_data, 64'h675A69675E5A6B5A);
        check_val("blk1_pulse_cnt", 64'(pulse_cnt), 64'd1);
        check_val("blk1_ack_cycles", 64'(ack_cnt), 64'd2);
        check_val("blk1_tx_bytes", rec_word, 64'hC1392F3D4C0A6588);
        check_val("blk1_tx_count", 64'(rec_n), 64'd8);
        check_val("blk1_issue_latency", 64'(pulse_cyc - last_rx_cyc), 64'd4);
        check_bit("blk1_core_encrypt", core_encrypt, 1'b1);

        // Stray core ready while idle, then decrypt block with a mode switch.
        core_trans_data       = 64'hDEADBEEFDEADBEEF;
        core_trans_data_ready = 1'b1;
        repeat (2) @(posedge tb_clk);
        #1;
        core_trans_data_ready = 1'b0;
        clear_obs();
        fork
            send_block(64'hC1392F3D4C0A6588, 1'b0, 1'b0);
            core_respond(40, 64'h675A69675E5A6B5A, 1'b0);
        join
        wait_idle("blk2_idle");
        check_bit("blk2_core_encrypt", core_encrypt, 1'b0);
        check_val("blk2_issue_latency", 64'(pulse_cyc - last_rx_cyc), 64'd4);
        check_val("blk2_tx_bytes", rec_word, 64'h675A69675E5A6B5A);
        check_val("blk2_ack_cycles", 64'(ack_cnt), 64'd2);

        // Same mode again (no settle), rx poked while busy, tx back-pressured.
        clear_obs();
        fork
            send_block(64'h0102030405060708, 1'b0, 1'b0);
            core_respond(12, 64'hA1B2C3D4E5F60718, 1'b1);
            drain_backpressure();
        join
        wait_idle("blk3_idle");
        check_val("blk3_issue_latency", 64'(pulse_cyc - last_rx_cyc), 64'd1);
        check_val("blk3_rcv_data", pulse_data, 64'h0102030405060708);
        check_val("blk3_tx_bytes", rec_word, 64'hA1B2C3D4E5F60718);
        check_val("blk3_tx_count", 64'(rec_n), 64'd8);

        // Reset in the middle of WAIT_CORE, then a late core result.
        clear_obs();
        send_block(64'h0011223344556677, 1'b0, 1'b0);
        n = 0;
        while (!core_rcv_data_ready && n < 100) begin
            @(negedge tb_clk);
            n++;
        end
        check_bit("blk4_pulse", core_rcv_data_ready, 1'b1);
        repeat (10) @(posedge tb_clk);
        #2;
        n_rst = 1'b0;
        #1;
        check_bit("rst_async_busy", busy, 1'b0);
        check_bit("rst_async_rx_ready", rx_ready, 1'b1);
        repeat (2) @(posedge tb_clk);
        #2;
        n_rst = 1'b1;
        clear_obs();
        @(posedge tb_clk);
        #1;
        core_trans_data       = 64'hFFEEDDCCBBAA9988;
        core_trans_data_ready = 1'b1;
        @(posedge tb_clk);
        #1;
        core_trans_data_ready = 1'b0;
        repeat (20) @(posedge tb_clk);
        #1;
        check_val("late_ready_tx_valid", 64'(tx_valid_cnt), 64'd0);
        check_val("late_ready_ack", 64'(ack_cnt), 64'd0);
        check_val("late_ready_pulse", 64'(pulse_cnt), 64'd0);
        check_bit("late_ready_busy", busy, 1'b0);

        // Timeout on the short-timeout instance: the core never answers.
        t_n_rst = 1'b1;
        @(posedge tb_clk);
        #1;
        check_bit("t_err_after_reset", t_err, 1'b0);
        for (int i = 7; i >= 0; i--) begin
            t_rx_byte  = 8'h30 + 8'(i);
            t_rx_valid = 1'b1;
            @(posedge tb_clk);
            #1;
        end
        t_rx_valid = 1'b0;
        n = 0;
        while (!t_rcv_ready && n < 100) begin
            @(negedge tb_clk);
            n++;
        end
        check_bit("t_pulse_seen", t_rcv_ready, 1'b1);
        check_val("t_rcv_data", t_rcv_data, 64'h3736353433323130);
        err_k = -1; idle_k = -1; t_ack_cnt = 0; t_txv_cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge tb_clk);
            if (t_err && err_k < 0) err_k = k;
            if (t_ack) t_ack_cnt++;
            if (t_tx_valid) t_txv_cnt++;
            if (!t_busy && idle_k < 0) idle_k = k;
        end
        // 16 WAIT_CORE cycles, then the flag shows one cycle after the aborting edge.
        check_val("t_err_cycle", 64'(err_k), 64'd17);
        check_val("t_ack_cycles", 64'(t_ack_cnt), 64'd2);
        check_val("t_tx_valid_cnt", 64'(t_txv_cnt), 64'd0);
        check_val("t_idle_cycle", 64'(idle_k), 64'd19);
        check_bit("t_rx_ready_idle", t_rx_ready, 1'b1);
        check_bit("t_err_sticky", t_err, 1'b1);
        check_bit("t_core_encrypt", t_enc, 1'b1);
        check_val("t_tx_byte_idle", 64'(t_tx_byte), 64'h0);
        @(posedge tb_clk);
        #2;
        t_n_rst = 1'b0;
        #1;
        check_bit("t_err_cleared_by_reset", t_err, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        fails++;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
